// File: rtl/cb_rom_resp_pkg.sv
// ---------------------------------------------------------------------------
// cb_rom_resp_pkg
// Core-bus shared types: address, response code, request/response bundles,
// plus the read-queue entry used by the ROM responder and a window helper.
// ---------------------------------------------------------------------------
package cb_rom_resp_pkg;

  typedef logic [31:0] cb_addr_t;
  typedef logic [31:0] cb_data_t;

  typedef enum logic [1:0] {
    CB_OKAY   = 2'b00,
    CB_EXOKAY = 2'b01,
    CB_SLVERR = 2'b10,
    CB_DECERR = 2'b11
  } cb_resp_t;

  // Initiator -> target
  typedef struct packed {
    cb_addr_t   rd_addr;
    logic [2:0] rd_size;
    logic       rd_addr_valid;
    logic       rd_ready;
    cb_addr_t   wr_addr;
    logic [2:0] wr_size;
    logic       wr_addr_valid;
    cb_data_t   wr_data;
    logic [3:0] wr_strb;
    logic       wr_data_valid;
    logic       wr_resp_ready;
  } s_cb_mosi_t;

  // Target -> initiator
  typedef struct packed {
    logic     rd_addr_ready;
    cb_data_t rd_data;
    cb_resp_t rd_resp;
    logic     rd_valid;
    logic     wr_addr_ready;
    logic     wr_data_ready;
    cb_resp_t wr_resp;
    logic     wr_resp_valid;
  } s_cb_miso_t;

  // One captured read response waiting to be returned
  typedef struct packed {
    cb_data_t data;
    cb_resp_t resp;
  } rd_entry_t;

  // True when addr falls inside [base, base + span)
  function automatic logic addr_in_window(input cb_addr_t addr,
                                          input cb_addr_t base,
                                          input cb_addr_t span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/cb_rom_resp_fifo_nox.sv
// ---------------------------------------------------------------------------
// fifo_nox
// Small show-ahead FIFO. The head entry is visible on data_o whenever
// ocup_o is non-zero. The caller guarantees no push when full and no pop
// when empty.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i/data_i write one entry
//   pop_i         drop the head entry
//   data_o        head entry
//   ocup_o        number of stored entries ($clog2(SLOTS)+1 bits)
// ---------------------------------------------------------------------------
module fifo_nox #(
  parameter int SLOTS = 2,
  parameter int WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(SLOTS):0] ocup_o
);

  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(SLOTS - 1);

  logic [WIDTH-1:0] slots [SLOTS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocup_o <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   ocup_o <= ocup_o + 1'b1;
        2'b01:   ocup_o <= ocup_o - 1'b1;
        default: ocup_o <= ocup_o;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately not reset; only the pointers and
  // count define validity, and leaving data unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) slots[wr_ptr] <= data_i;
  end

  assign data_o = slots[rd_ptr];

endmodule

// File: rtl/cb_rom_resp.sv
// ---------------------------------------------------------------------------
// cb_rom_resp
// Core-bus read-only memory target. Reads are looked up and range-checked
// at address acceptance, queued, and returned in order after WAIT_STATES
// cycles each. A side program port fills the memory.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cb_mosi_i       core-bus request (read + write channels)
//   cb_miso_o       core-bus response
//   prog_we_i       program-write strobe
//   prog_addr_i     program byte address
//   prog_data_i     program data
// Build option: define CB_ROM_RESP_WR_ERR_EN to accept writes and answer
// each with CB_SLVERR; otherwise the write channel is tied off and stalls.
// ---------------------------------------------------------------------------
module cb_rom_resp
  import cb_rom_resp_pkg::*;
#(
  parameter cb_addr_t BASE_ADDR   = 32'h8000_0000,
  parameter int       MEM_WORDS   = 1024,
  parameter int       WAIT_STATES = 0,
  parameter int       MAX_OT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  s_cb_mosi_t  cb_mosi_i,
  output s_cb_miso_t  cb_miso_o,
  input  logic        prog_we_i,
  input  cb_addr_t    prog_addr_i,
  input  logic [31:0] prog_data_i
);

  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W  = $clog2(MAX_OT) + 1;
  localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam cb_addr_t          WIN_BYTES = cb_addr_t'(MEM_WORDS * 4);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OT);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [31:0]       mem [MEM_WORDS];
  r_state_t          state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic [CNT_W-1:0]  pend_cnt;
  rd_entry_t         push_entry, head;
  logic              addr_ready, accept, rd_valid, pop;

  // ---- read lookup at acceptance --------------------------------------------
  cb_addr_t rd_off, prog_off;
  logic     rd_in_win, prog_in_win;

  assign rd_off      = cb_mosi_i.rd_addr - BASE_ADDR;
  assign prog_off    = prog_addr_i - BASE_ADDR;
  assign rd_in_win   = addr_in_window(cb_mosi_i.rd_addr, BASE_ADDR, WIN_BYTES);
  assign prog_in_win = addr_in_window(prog_addr_i, BASE_ADDR, WIN_BYTES);

  // Full-count gating only; never looks at rd_ready/rd_valid.
  assign addr_ready = !rst && (pend_cnt < MAX_CNT);
  assign accept     = cb_mosi_i.rd_addr_valid && addr_ready;
  assign rd_valid   = (state == R_RESP) && !rst;
  assign pop        = rd_valid && cb_mosi_i.rd_ready;

  // The read samples mem before this edge's program write lands, so a
  // same-cycle write to the same word returns the old data.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    push_entry = '{data: '0, resp: CB_SLVERR};
    if (rd_in_win) push_entry = '{data: mem[rd_off[IDX_W+1:2]], resp: CB_OKAY};
  end

  always_ff @(posedge clk) begin
    if (prog_we_i && prog_in_win) mem[prog_off[IDX_W+1:2]] <= prog_data_i;
  end

  fifo_nox #(
    .SLOTS (MAX_OT),
    .WIDTH ($bits(rd_entry_t))
  ) u_pending (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head),
    .ocup_o (pend_cnt)
  );

  // ---- response FSM: state register -----------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // ---- response FSM: next state ---------------------------------------------
  // A new head is "started" either when it arrives in an empty queue or when
  // the previous head pops; it is pushed in the same cycle, so the state
  // change is decided from accept rather than from the queue count.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      R_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = R_RESP;
          end else begin
            state_next    = R_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt <= WAIT_W'(1)) begin
          state_next    = R_RESP;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt - WAIT_W'(1);
        end
      end
      R_RESP: begin
        if (cb_mosi_i.rd_ready) begin
          if ((pend_cnt > CNT_W'(1)) || accept) begin
            if (WAIT_STATES != 0) begin
              state_next    = R_WAIT;
              wait_cnt_next = WAIT_LOAD;
            end
          end else begin
            state_next = R_IDLE;
          end
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  // ---- write channel ----------------------------------------------------------
`ifdef CB_ROM_RESP_WR_ERR_EN
  logic aw_done, w_done, b_valid, wr_addr_ready, wr_data_ready, aw_hs, w_hs;

  assign wr_addr_ready = !rst && !b_valid && !aw_done;
  assign wr_data_ready = !rst && !b_valid && !w_done;
  assign aw_hs         = cb_mosi_i.wr_addr_valid && wr_addr_ready;
  assign w_hs          = cb_mosi_i.wr_data_valid && wr_data_ready;

  // Address and data may arrive in either order; one error response is
  // raised once both have been taken. Memory is never touched.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      b_valid <= 1'b0;
    end else if (b_valid) begin
      if (cb_mosi_i.wr_resp_ready) b_valid <= 1'b0;
    end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
      b_valid <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_done || aw_hs;
      w_done  <= w_done || w_hs;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cb_mosi_i.rd_size, rd_off[1:0], rd_off[31:IDX_W+2],
                         prog_off[1:0], prog_off[31:IDX_W+2], cb_mosi_i.wr_addr,
                         cb_mosi_i.wr_size, cb_mosi_i.wr_data, cb_mosi_i.wr_strb};
`else
  logic unused_bits;
  assign unused_bits = ^{cb_mosi_i.rd_size, rd_off[1:0], rd_off[31:IDX_W+2],
                         prog_off[1:0], prog_off[31:IDX_W+2], cb_mosi_i.wr_addr,
                         cb_mosi_i.wr_size, cb_mosi_i.wr_addr_valid,
                         cb_mosi_i.wr_data, cb_mosi_i.wr_strb,
                         cb_mosi_i.wr_data_valid, cb_mosi_i.wr_resp_ready};
`endif

  // ---- response FSM: outputs -------------------------------------------------
  always_comb begin
    cb_miso_o               = '0;
    cb_miso_o.rd_resp       = CB_OKAY;
    cb_miso_o.wr_resp       = CB_OKAY;
    cb_miso_o.rd_addr_ready = addr_ready;
    cb_miso_o.rd_valid      = rd_valid;
    if (rd_valid) begin
      cb_miso_o.rd_data = head.data;
      cb_miso_o.rd_resp = head.resp;
    end
`ifdef CB_ROM_RESP_WR_ERR_EN
    cb_miso_o.wr_addr_ready = wr_addr_ready;
    cb_miso_o.wr_data_ready = wr_data_ready;
    cb_miso_o.wr_resp_valid = b_valid && !rst;
    if (b_valid && !rst) cb_miso_o.wr_resp = CB_SLVERR;
`endif
  end

endmodule

// File: tb/tb_cb_rom_resp.sv
// ---------------------------------------------------------------------------
// tb_cb_rom_resp
// Two instances: dut_a (WAIT_STATES=0) with a queue scoreboard and random
// traffic, dut_b (WAIT_STATES=3) for wait-state latency. Expected read
// results come from a reference memory array written alongside the
// program port.
// ---------------------------------------------------------------------------
module tb_cb_rom_resp;
  import cb_rom_resp_pkg::*;

  localparam cb_addr_t BASE     = 32'h8000_0000;
  localparam int       WORDS    = 64;
  localparam cb_addr_t END_ADDR = BASE + cb_addr_t'(WORDS * 4);
  localparam int       WS_B     = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  s_cb_mosi_t  mosi_a, mosi_b;
  s_cb_miso_t  miso_a, miso_b;
  logic        prog_we;
  cb_addr_t    prog_addr;
  logic [31:0] prog_data;

  always #5 clk = ~clk;

  cb_rom_resp #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(0), .MAX_OT(2)) dut_a (
    .clk(clk), .rst(rst), .cb_mosi_i(mosi_a), .cb_miso_o(miso_a),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data));

  cb_rom_resp #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(WS_B), .MAX_OT(2)) dut_b (
    .clk(clk), .rst(rst), .cb_mosi_i(mosi_b), .cb_miso_o(miso_b),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data));

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [31:0] ref_mem [WORDS];
  rd_entry_t   exp_q [$];
  int          pop_cyc [$];
  int          acc_cyc [$];
  int          vcyc [$];
  logic [31:0] vdat [$];
  logic        stalled = 1'b0;
  logic        rand_done;
  logic        saw;
  int          c0, n;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: word lookup inside the window, error outside.
  function automatic rd_entry_t model(input cb_addr_t a);
    rd_entry_t e;
    if (a < BASE || a >= END_ADDR) begin
      e.data = '0;
      e.resp = CB_SLVERR;
    end else begin
      e.data = ref_mem[int'((a - BASE) >> 2)];
      e.resp = CB_OKAY;
    end
    return e;
  endfunction

  // Starts and ends at posedge+1. Expectation captured at the accepting cycle.
  task automatic issue(input cb_addr_t a);
    int  k = 0;
    logic done = 1'b0;
    mosi_a.rd_addr       = a;
    mosi_a.rd_size       = 3'($urandom_range(0, 2));
    mosi_a.rd_addr_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (miso_a.rd_addr_ready) begin
        exp_q.push_back(model(a));
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end else if (++k > 100) begin
        check("accept_timeout", miso_a.rd_addr_ready, 1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1 mosi_a.rd_addr_valid = 1'b0;
  endtask

  task automatic prog_write(input cb_addr_t a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    if (a >= BASE && a < END_ADDR) ref_mem[int'((a - BASE) >> 2)] = d;
    #1 prog_we = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for dut_a
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("rd_valid_held", miso_a.rd_valid, 1);
      if (miso_a.rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_unexpected", miso_a.rd_valid, 0);
        end else begin
          check("rd_data", miso_a.rd_data, exp_q[0].data);
          check("rd_resp", miso_a.rd_resp, exp_q[0].resp);
          if (mosi_a.rd_ready) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc);
          end
        end
      end
      stalled = miso_a.rd_valid && !mosi_a.rd_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mosi_a = '0; mosi_b = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rst = 1'b1;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_rd_addr_ready", miso_a.rd_addr_ready, 0);
    check("rst_rd_valid", miso_a.rd_valid, 0);
    check("rst_rd_data", miso_a.rd_data, 0);
    check("rst_rd_resp", miso_a.rd_resp, CB_OKAY);
    check("rst_wr_addr_ready", miso_a.wr_addr_ready, 0);
    check("rst_wr_resp_valid", miso_a.wr_resp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst_a", miso_a.rd_addr_ready, 1);
    check("ready_after_rst_b", miso_b.rd_addr_ready, 1);
    @(posedge clk);
    #1;

    // ---- preload ----
    for (int i = 0; i < WORDS; i++) prog_write(BASE + cb_addr_t'(i * 4), $urandom);
    prog_write(BASE + 0,  32'h11);
    prog_write(BASE + 4,  32'h22);
    prog_write(BASE + 8,  32'h33);
    prog_write(BASE + 12, 32'h44);
    prog_write(END_ADDR, 32'hBAD0_0001);   // out of window: ignored
    prog_write(BASE - 4, 32'hBAD0_0002);   // out of window: ignored

    // ---- back-to-back, zero wait ----
    mosi_a.rd_ready = 1'b1;
    pop_cyc.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) issue(BASE + cb_addr_t'(i * 4));
    wait_drain();
    check("b2b_count", 64'(pop_cyc.size()), 4);
    if (pop_cyc.size() == 4) begin
      check("b2b_first_latency", 64'(pop_cyc[0] - acc_cyc[0]), 1);
      for (int i = 1; i < 4; i++) check("b2b_consecutive", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
    end
    issue(END_ADDR - 4 + 3);               // last word, low bits ignored
    wait_drain();

    // ---- backpressure ----
    mosi_a.rd_ready = 1'b0;
    issue(BASE + 8);
    issue(BASE + 12);
    fork
      issue(BASE + 16);
      begin
        repeat (3) @(negedge clk);
        check("full_addr_ready", miso_a.rd_addr_ready, 0);
        check("full_rd_valid", miso_a.rd_valid, 1);
        @(posedge clk);
        #1 mosi_a.rd_ready = 1'b1;
      end
    join
    wait_drain();

    // ---- same-cycle program write vs read; queued entry keeps captured data ----
    fork
      issue(BASE + 20);
      prog_write(BASE + 20, 32'hCAFE_0005);
    join
    issue(BASE + 20);
    wait_drain();
    mosi_a.rd_ready = 1'b0;
    issue(BASE + 24);
    prog_write(BASE + 24, 32'hCAFE_0006);
    @(posedge clk);
    #1 mosi_a.rd_ready = 1'b1;
    wait_drain();

    // ---- window check ----
    issue(END_ADDR);
    issue(BASE + 28);
    issue(BASE - 4);
    issue(32'hFFFF_FFFC);
    issue(BASE + 2);
    wait_drain();

    // ---- wait states on dut_b ----
    mosi_b.rd_ready      = 1'b1;
    mosi_b.rd_addr       = BASE + 4;
    mosi_b.rd_addr_valid = 1'b1;
    @(negedge clk);
    check("b_ready_first", miso_b.rd_addr_ready, 1);
    c0 = cyc;
    @(posedge clk);
    #1 mosi_b.rd_addr = BASE + 8;
    @(negedge clk);
    check("b_ready_second", miso_b.rd_addr_ready, 1);
    @(posedge clk);
    #1 mosi_b.rd_addr_valid = 1'b0;
    vcyc.delete(); vdat.delete();
    repeat (20) begin
      @(negedge clk);
      if (miso_b.rd_valid) begin
        vcyc.push_back(cyc);
        vdat.push_back(miso_b.rd_data);
      end
    end
    check("ws_resp_count", 64'(vcyc.size()), 2);
    if (vcyc.size() == 2) begin
      check("ws_first_latency", 64'(vcyc[0] - c0), 64'(1 + WS_B));
      check("ws_second_latency", 64'(vcyc[1] - c0), 64'(2 * (1 + WS_B)));
      check("ws_first_data", vdat[0], ref_mem[1]);
      check("ws_second_data", vdat[1], ref_mem[2]);
    end
    @(posedge clk);
    #1;

    // ---- reset with reads pending ----
    mosi_a.rd_ready = 1'b0;
    issue(BASE + 4);
    issue(BASE + 8);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (miso_a.rd_valid) saw = 1'b1;
    end
    check("no_valid_after_reset", saw, 0);
    @(posedge clk);
    #1 mosi_a.rd_ready = 1'b1;
    issue(BASE + 4);
    issue(BASE + 0);
    wait_drain();

    // ---- random traffic with random backpressure and program writes ----
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) mosi_a.rd_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 8) begin
            prog_write(BASE + cb_addr_t'($urandom_range(0, WORDS - 1) * 4), $urandom);
          end else if (r < 10) begin
            prog_write(END_ADDR + cb_addr_t'($urandom_range(0, 3) * 4), $urandom);
          end else if (r < 16) begin
            issue(BASE - cb_addr_t'($urandom_range(1, 4) * 4));
          end else if (r < 22) begin
            issue(END_ADDR + cb_addr_t'($urandom_range(0, 3) * 4));
          end else begin
            issue(BASE + cb_addr_t'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(0, 3)));
          end
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
    join
    mosi_a.rd_ready = 1'b1;
    wait_drain();

    // ---- write channel ----
`ifdef CB_ROM_RESP_WR_ERR_EN
    mosi_a.wr_addr = BASE; mosi_a.wr_size = 3'd2; mosi_a.wr_data = 32'hDEAD;
    mosi_a.wr_strb = 4'hF; mosi_a.wr_resp_ready = 1'b0;
    mosi_a.wr_addr_valid = 1'b1; mosi_a.wr_data_valid = 1'b1;
    @(negedge clk);
    check("wr_addr_ready_idle", miso_a.wr_addr_ready, 1);
    check("wr_data_ready_idle", miso_a.wr_data_ready, 1);
    @(posedge clk);
    #1 mosi_a.wr_addr_valid = 1'b0; mosi_a.wr_data_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!miso_a.wr_resp_valid && n < 10);
    check("wr_resp_valid", miso_a.wr_resp_valid, 1);
    check("wr_resp_slverr", miso_a.wr_resp, CB_SLVERR);
    repeat (3) @(negedge clk);
    check("wr_resp_held", miso_a.wr_resp_valid, 1);
    @(posedge clk);
    #1 mosi_a.wr_resp_ready = 1'b1;
    @(posedge clk);
    #1 mosi_a.wr_resp_ready = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (miso_a.wr_resp_valid) saw = 1'b1;
    end
    check("wr_resp_single", saw, 0);
    @(posedge clk);
    #1;
`else
    mosi_a.wr_addr = BASE; mosi_a.wr_data = 32'hDEAD; mosi_a.wr_strb = 4'hF;
    mosi_a.wr_addr_valid = 1'b1; mosi_a.wr_data_valid = 1'b1; mosi_a.wr_resp_ready = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (miso_a.wr_addr_ready || miso_a.wr_data_ready || miso_a.wr_resp_valid) saw = 1'b1;
    end
    check("wr_channel_stalled", saw, 0);
    check("wr_addr_ready_tied", miso_a.wr_addr_ready, 0);
    @(posedge clk);
    #1 mosi_a.wr_addr_valid = 1'b0; mosi_a.wr_data_valid = 1'b0;
`endif
    issue(BASE);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cb_rom_resp.md
CB_ROM_RESP -- requirements
Module: cb_rom_resp

Interface
REQ-001 Parameters: BASE_ADDR, default 32'h8000_0000, base byte address of the window; MEM_WORDS, default 1024, number of 32-bit words; WAIT_STATES, default 0, extra cycles before each response; MAX_OT, default 2, maximum accepted-but-unreturned reads.
REQ-002 Clock and reset ports: clk input 1, clock; rst input 1, reset; one clock; reset is synchronous and active-high.
REQ-003 Core-bus request port: cb_mosi_i input s_cb_mosi_t, core-bus request from the initiator (rd_addr, rd_size, rd_addr_valid, rd_ready, wr_* fields).
REQ-004 Core-bus response port: cb_miso_o output s_cb_miso_t, core-bus response to the initiator (rd_addr_ready, rd_data, rd_resp, rd_valid, wr_* fields).
REQ-005 Program-write port: prog_we_i input 1, program-write strobe; prog_addr_i input cb_addr_t, program byte address; prog_data_i input 32, program data.

Function
REQ-006 Read address acceptance SHALL occur on a cycle with rd_addr_valid && rd_addr_ready high.
REQ-007 rd_addr_ready SHALL be high only when the pending count < MAX_OT, with no combinational dependency on rd_ready or rd_valid.
REQ-008 Data lookup and address check SHALL happen at acceptance: word index = (rd_addr - BASE_ADDR) >> 2; {data, resp} pushed into the pending queue in the same cycle.
REQ-009 Out-of-window address (rd_addr < BASE_ADDR or >= BASE_ADDR + 4*MEM_WORDS) SHALL push resp = CB_SLVERR and data = 0; otherwise resp = CB_OKAY.
REQ-010 Responses SHALL be returned strictly in acceptance order.
REQ-011 Response FSM states: R_IDLE (queue empty), R_WAIT (head present, wait counter > 0), R_RESP (rd_valid high).
REQ-012 Transition on head arrival or pop: if WAIT_STATES = 0, the FSM SHALL enter R_RESP; otherwise it SHALL enter R_WAIT with the counter loaded to WAIT_STATES.
REQ-013 R_WAIT: the counter SHALL decrement each cycle and the FSM SHALL go to R_RESP when the counter reaches 0.
REQ-014 Minimum latency: acceptance at cycle N gives rd_valid at cycle N+1+WAIT_STATES when the queue was empty.
REQ-015 While rd_valid && ~rd_ready: rd_data and rd_resp SHALL stay stable and no later response SHALL be presented.
REQ-016 On rd_valid && rd_ready, the head SHALL pop and the next entry, if present, SHALL restart its wait per REQ-012; with WAIT_STATES = 0 this gives back-to-back rd_valid.
REQ-017 Simultaneous push and pop SHALL leave the count unchanged; a push at count == MAX_OT SHALL never occur.
REQ-018 The pending count SHALL be $clog2(MAX_OT)+1 bits wide and SHALL never wrap.
REQ-019 prog_we_i SHALL write the memory word in one cycle; an out-of-window address SHALL be ignored.
REQ-020 A program write in the same cycle as an accept to the same word SHALL give the read the old data; queued entries SHALL keep their captured data.
REQ-021 rd_size SHALL be ignored (full word always returned); the low two address bits SHALL be ignored.

Reset
REQ-022 On rst: queue emptied, FSM set to R_IDLE, wait counter 0, rd_valid 0, rd_data 0, rd_resp CB_OKAY, rd_addr_ready 0 during the reset cycle, all wr_* outputs 0.
REQ-023 Reset mid-operation SHALL drop all pending responses without emitting them; memory contents SHALL be preserved.
REQ-024 rd_addr_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-025 Macro CB_ROM_RESP_WR_ERR_EN: when defined, a write address and write data handshake each SHALL be accepted (wr_addr_ready = wr_data_ready = 1 while no write response is outstanding).
REQ-026 With CB_ROM_RESP_WR_ERR_EN defined, exactly one wr_resp = CB_SLVERR SHALL be returned, held until wr_resp_ready, and memory SHALL NOT be modified.
REQ-027 With CB_ROM_RESP_WR_ERR_EN undefined, all wr_* outputs SHALL be tied 0 and write requests SHALL stall indefinitely.

Structure
REQ-028 cb_resp_t, s_cb_mosi_t, s_cb_miso_t and cb_addr_t SHALL be reused from the existing core-bus package; the response FSM enum SHALL be local to the module.
REQ-029 The pending queue SHALL be one fifo_nox instance (SLOTS = MAX_OT, WIDTH = 32 + response width); its ocup_o SHALL drive the pending count.

Verification
REQ-030 Back-to-back: preload words 0..3 = 0x11,0x22,0x33,0x44; four reads at BASE_ADDR+0..12 with WAIT_STATES=0 and rd_ready=1 -> data 0x11..0x44, CB_OKAY, rd_valid on consecutive cycles.
REQ-031 Backpressure: MAX_OT=2, rd_ready=0 -> third address stalls with rd_addr_ready=0; rd_ready=1 -> responses in order, data stable while stalled.
REQ-032 Window check: read BASE_ADDR + 4*MEM_WORDS -> rd_resp=CB_SLVERR, rd_data=0; the following in-window read -> CB_OKAY.
REQ-033 Wait states: WAIT_STATES=3, accept at cycle 10 -> rd_valid first at cycle 14.
REQ-034 Reset: rst pulsed with 2 reads pending -> no rd_valid afterwards; re-read returns the preloaded data.
REQ-035 Macro: with CB_ROM_RESP_WR_ERR_EN, write 0xDEAD to BASE_ADDR -> CB_SLVERR, a later read returns the original word; without it -> wr_addr_ready stays 0.
